// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one combinational ALU between two issue slots. Each slot offers an
//   operation over valid/ready. One operation is accepted at a time. It is
//   registered and driven onto the ALU for one cycle, and the ALU result is
//   captured. The result is then returned to the owning slot over valid/ready.
//   Arbitration is round-robin (PRIO_MODE=0) or fixed priority to slot 0
//   (PRIO_MODE=1).
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   reqK_valid/ready/a/b/op    operation channel for slot K (K = 0, 1)
//   rspK_valid/ready/r/ov      response channel for slot K
//   alu_a/alu_b/alu_control    operands and control code driven to the ALU
//   alu_r/alu_intov            result and bit-WIDTH flag returned by the ALU
//   busy                       high whenever the controller is not idle
//   done0_cnt/done1_cnt        completed-operation counters, wrapping
module alu_share_ctrl #(
  parameter int WIDTH     = 32,
  parameter int OPW       = 5,
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_r,
  output logic             rsp0_ov,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_r,
  output logic             rsp1_ov,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_intov,
  output logic             busy,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nx;
  logic             rr;        // slot favoured by round-robin: 0 or 1
  logic             owner;     // slot that owns the in-flight operation
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [OPW-1:0]   op_q;
  logic             ov_q;

  logic fav, v_fav, v_oth, grant, grant_valid, rsp_hs;

  // Fixed priority simply pins the favoured slot to 0 and ignores rr.
  assign fav         = (PRIO_MODE != 0) ? 1'b0 : rr;
  assign v_fav       = fav ? req1_valid : req0_valid;
  assign v_oth       = fav ? req0_valid : req1_valid;
  assign grant       = v_fav ? fav : ~fav;
  // Gating with reset keeps ready low while reset is held, even if a
  // requester keeps valid high through it.
  assign grant_valid = reset && (state == IDLE) && (v_fav || v_oth);

  assign req0_ready  = grant_valid && !grant;
  assign req1_ready  = grant_valid &&  grant;

  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) &&  owner;
  assign rsp_hs      = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  // Both slots see the captured result; only rspK_valid qualifies it.
  assign rsp0_r  = r_q;
  assign rsp1_r  = r_q;
  assign rsp0_ov = ov_q;
  assign rsp1_ov = ov_q;

  assign busy    = (state != IDLE);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_valid) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outside EXEC the ALU sees its default code (all ones, result 0). While
  // reset is held, every output is 0, including the control code.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = reset ? '1 : '0;
    if (state == EXEC) begin
      alu_a       = a_q;
      alu_b       = b_q;
      alu_control = op_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register updated at this edge then reads the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr        <= 1'b0;
      owner     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      r_q       <= '0;
      ov_q      <= 1'b0;
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (grant_valid) begin
          owner <= grant;
          a_q   <= grant ? req1_a  : req0_a;
          b_q   <= grant ? req1_b  : req0_b;
          op_q  <= grant ? req1_op : req0_op;
        end
        EXEC: begin
          r_q  <= alu_r;
          ov_q <= alu_intov;
        end
        RESP: if (rsp_hs) begin
          rr <= ~owner;
          if (owner) done1_cnt <= done1_cnt + 1'b1;
          else       done0_cnt <= done0_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl. It instantiates a round-robin
// instance (dut) and a fixed-priority instance (dut_p). Each instance has its
// own behavioural ALU attached.
module tb_alu_share_ctrl;
  localparam int W   = 32;
  localparam int OPW = 5;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Operation data shared by both instances.
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;

  // Round-robin instance.
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_ov, rsp1_ov, busy;
  logic [W-1:0] rsp0_r, rsp1_r, alu_a, alu_b, alu_r;
  logic [OPW-1:0] alu_control;
  logic alu_intov;
  logic [CW-1:0] done0_cnt, done1_cnt;

  // Fixed-priority instance.
  logic p_req0_valid = 0, p_req1_valid = 0;
  logic p_req0_ready, p_req1_ready, p_rsp0_valid, p_rsp1_valid, p_rsp0_ov, p_rsp1_ov, p_busy;
  logic [W-1:0] p_rsp0_r, p_rsp1_r, p_alu_a, p_alu_b, p_alu_r;
  logic [OPW-1:0] p_alu_control;
  logic p_alu_intov;
  logic [CW-1:0] p_done0_cnt, p_done1_cnt;

  int n_pass = 0;
  int n_total = 0;

  // ALU behaviour: 1 add, 2 sub, 3 and, 4 or, 5 xor, otherwise 0.
  // Bit W is the carry or borrow of the add/sub.
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [OPW-1:0] op);
    case (op)
      5'd1:    return {1'b0, a} + {1'b0, b};
      5'd2:    return {1'b0, a} - {1'b0, b};
      5'd3:    return {1'b0, a & b};
      5'd4:    return {1'b0, a | b};
      5'd5:    return {1'b0, a ^ b};
      default: return '0;
    endcase
  endfunction

  assign {alu_intov, alu_r}     = alu_ref(alu_a, alu_b, alu_control);
  assign {p_alu_intov, p_alu_r} = alu_ref(p_alu_a, p_alu_b, p_alu_control);

  alu_share_ctrl #(.WIDTH(W), .OPW(OPW), .PRIO_MODE(0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r), .rsp0_ov(rsp0_ov),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_ov(rsp1_ov),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_r(alu_r), .alu_intov(alu_intov),
    .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
  );

  alu_share_ctrl #(.WIDTH(W), .OPW(OPW), .PRIO_MODE(1), .CNT_W(CW)) dut_p (
    .clk(clk), .reset(reset),
    .req0_valid(p_req0_valid), .req0_ready(p_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(p_req1_valid), .req1_ready(p_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(p_rsp0_valid), .rsp0_ready(1'b1), .rsp0_r(p_rsp0_r), .rsp0_ov(p_rsp0_ov),
    .rsp1_valid(p_rsp1_valid), .rsp1_ready(1'b1), .rsp1_r(p_rsp1_r), .rsp1_ov(p_rsp1_ov),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_control(p_alu_control), .alu_r(p_alu_r), .alu_intov(p_alu_intov),
    .busy(p_busy), .done0_cnt(p_done0_cnt), .done1_cnt(p_done1_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operation on a slot and waits, bounded, for its response.
  // Both response readies are expected to be high.
  task automatic do_op(input int slot, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OPW-1:0] op, output logic [W-1:0] r, output logic ov);
    int n;
    r = '0;
    ov = 1'b0;
    if (slot == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else           begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    #1;
    n = 0;
    while (!((slot == 0) ? req0_ready : req1_ready) && n < 20) begin tick(); n++; end
    check($sformatf("accept slot%0d in time", slot), n < 20, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!((slot == 0) ? rsp0_valid : rsp1_valid) && n < 20) begin tick(); n++; end
    check($sformatf("response slot%0d in time", slot), n < 20, 1);
    check($sformatf("other rsp_valid low slot%0d", slot), (slot == 0) ? rsp1_valid : rsp0_valid, 0);
    r  = (slot == 0) ? rsp0_r : rsp1_r;
    ov = (slot == 0) ? rsp0_ov : rsp1_ov;
    tick();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  typedef struct {
    int             slot;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
    logic [W-1:0]   r;
    logic           ov;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic ov;
    int grants[$];
    int n;
    int req1_seen;
    logic seen_rsp;

    vecs[0] = '{0, 32'd5,        32'd3,        5'd1,  32'd8,        1'b0};
    vecs[1] = '{1, 32'hFFFFFFFF, 32'd1,        5'd1,  32'd0,        1'b1};
    vecs[2] = '{0, 32'd10,       32'd3,        5'd2,  32'd7,        1'b0};
    vecs[3] = '{1, 32'd3,        32'd10,       5'd2,  32'hFFFFFFF9, 1'b1};
    vecs[4] = '{0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3,  32'h00F000F0, 1'b0};
    vecs[5] = '{1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd4,  32'hFFF0FFF0, 1'b0};
    vecs[6] = '{0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd5,  32'hFF00FF00, 1'b0};
    vecs[7] = '{1, 32'h80000000, 32'h80000000, 5'd1,  32'd0,        1'b1};
    vecs[8] = '{0, 32'd123,      32'd456,      5'd31, 32'd0,        1'b0};

    // Reset state: every output is 0 while reset is held.
    #3;
    check("reset req0_ready", req0_ready, 0);
    check("reset rsp0_valid", rsp0_valid, 0);
    check("reset alu_control", alu_control, 0);
    check("reset busy", busy, 0);
    check("reset done0_cnt", done0_cnt, 0);
    check("reset done1_cnt", done1_cnt, 0);
    tick();
    reset = 1'b1;
    tick();
    check("idle alu_control", alu_control, 5'h1F);
    check("idle alu_a", alu_a, 0);

    // Single add, with cycle-by-cycle latency.
    tick();
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 5'd1; req0_valid = 1'b1;
    #1;
    check("t1 req0_ready", req0_ready, 1);
    check("t1 req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t1 exec busy", busy, 1);
    check("t1 exec rsp0_valid", rsp0_valid, 0);
    check("t1 exec req0_ready", req0_ready, 0);
    check("t1 exec alu_a", alu_a, 5);
    check("t1 exec alu_b", alu_b, 3);
    check("t1 exec alu_control", alu_control, 1);
    tick();
    check("t1 resp rsp0_valid", rsp0_valid, 1);
    check("t1 resp rsp1_valid", rsp1_valid, 0);
    check("t1 resp rsp0_r", rsp0_r, 8);
    check("t1 resp rsp0_ov", rsp0_ov, 0);
    check("t1 resp alu_control", alu_control, 5'h1F);
    tick();
    check("t1 done0_cnt", done0_cnt, 1);
    check("t1 idle busy", busy, 0);

    // Table of single operations on alternating slots.
    foreach (vecs[i]) begin
      do_op(vecs[i].slot, vecs[i].a, vecs[i].b, vecs[i].op, r, ov);
      check($sformatf("vec%0d r", i), r, vecs[i].r);
      check($sformatf("vec%0d ov", i), ov, vecs[i].ov);
    end
    check("table done0_cnt", done0_cnt, 6);
    check("table done1_cnt", done1_cnt, 4);

    // Round-robin contention from a fresh reset: grants alternate from slot 0.
    reset_dut();
    check("rr reset done0_cnt", done0_cnt, 0);
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 5'd1;
    req1_a = 32'd7; req1_b = 32'd4; req1_op = 5'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n = 0;
    while (grants.size() < 8 && n < 60) begin
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (grants.size() < 8) begin tick(); n++; end
    end
    check("rr grant count", grants.size(), 8);
    foreach (grants[i]) check($sformatf("rr grant %0d", i), grants[i], i % 2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
    check("rr done0_cnt", done0_cnt, 4);
    check("rr done1_cnt", done1_cnt, 4);

    // Fixed priority: slot 0 wins every time and slot 1 never sees ready.
    grants.delete();
    req1_seen = 0;
    p_req0_valid = 1'b1; p_req1_valid = 1'b1;
    #1;
    n = 0;
    while (grants.size() < 3 && n < 40) begin
      if (p_req0_ready) grants.push_back(0);
      if (p_req1_ready) begin grants.push_back(1); req1_seen++; end
      if (grants.size() < 3) begin tick(); n++; end
    end
    tick();
    p_req0_valid = 1'b0; p_req1_valid = 1'b0;
    repeat (3) tick();
    check("prio grant count", grants.size(), 3);
    foreach (grants[i]) check($sformatf("prio grant %0d", i), grants[i], 0);
    check("prio req1_ready seen", req1_seen, 0);
    check("prio done0_cnt", p_done0_cnt, 3);
    check("prio done1_cnt", p_done1_cnt, 0);

    // Back-pressure on the response: the result holds, and slot 1 is kept waiting.
    rsp0_ready = 1'b0;
    req0_a = 32'd7; req0_b = 32'd9; req0_op = 5'd1; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    check("bp accept in time", n < 20, 1);
    tick();
    req0_valid = 1'b0;
    req1_a = 32'd2; req1_b = 32'd2; req1_op = 5'd1; req1_valid = 1'b1;
    #1;
    n = 0;
    while (!rsp0_valid && n < 20) begin tick(); n++; end
    check("bp response in time", n < 20, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d rsp0_valid", i), rsp0_valid, 1);
      check($sformatf("bp%0d rsp0_r", i), rsp0_r, 16);
      check($sformatf("bp%0d busy", i), busy, 1);
      check($sformatf("bp%0d req1_ready", i), req1_ready, 0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    tick();
    check("bp released busy", busy, 0);
    check("bp released req1_ready", req1_ready, 1);
    check("bp done0_cnt", done0_cnt, 5);
    // Slot 1 withdraws before its handshake: nothing is accepted.
    req1_valid = 1'b0;
    #1;
    tick();
    check("bp withdrawn busy", busy, 0);

    // Reset while the controller is in EXEC: the operation is discarded.
    req0_a = 32'd11; req0_b = 32'd22; req0_op = 5'd1; req0_valid = 1'b1;
    #1;
    check("rst6 req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("rst6 in exec", busy, 1);
    reset = 1'b0;
    #1;
    check("rst6 req0_ready", req0_ready, 0);
    check("rst6 req1_ready", req1_ready, 0);
    check("rst6 rsp0_valid", rsp0_valid, 0);
    check("rst6 rsp1_valid", rsp1_valid, 0);
    check("rst6 rsp0_r", rsp0_r, 0);
    check("rst6 rsp0_ov", rsp0_ov, 0);
    check("rst6 alu_a", alu_a, 0);
    check("rst6 alu_b", alu_b, 0);
    check("rst6 alu_control", alu_control, 0);
    check("rst6 busy", busy, 0);
    check("rst6 done0_cnt", done0_cnt, 0);
    check("rst6 done1_cnt", done1_cnt, 0);
    tick();
    req1_valid = 1'b0;
    reset = 1'b1;
    seen_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp0_valid || rsp1_valid) seen_rsp = 1'b1;
    end
    check("rst6 no response after release", seen_rsp, 0);
    check("rst6 done0_cnt after release", done0_cnt, 0);

    // Random traffic against a transaction-level model. The model tracks one
    // pending operation, the number of cycles since it was accepted, and the
    // slot that won most recently.
    begin
      logic pend;
      int age, own, fav, win;
      int cnt[2];
      logic [W:0] exp_res;
      logic [1:0] v, rdy;
      logic [W-1:0] a0, b0, a1, b1;
      logic [OPW-1:0] o0, o1;
      logic rv;
      pend = 1'b0; age = 0; own = 0; fav = 0; exp_res = '0;
      cnt[0] = 0; cnt[1] = 0;
      for (int c = 0; c < 600; c++) begin
        v   = 2'($urandom_range(0, 3));
        rdy = 2'($urandom_range(0, 3));
        a0 = $urandom; b0 = $urandom; o0 = 5'($urandom_range(0, 7));
        a1 = $urandom; b1 = $urandom; o1 = 5'($urandom_range(0, 7));
        req0_a = a0; req0_b = b0; req0_op = o0; req0_valid = v[0];
        req1_a = a1; req1_b = b1; req1_op = o1; req1_valid = v[1];
        rsp0_ready = rdy[0]; rsp1_ready = rdy[1];
        #1;
        win = -1;
        if (!pend) begin
          if (v[fav]) win = fav;
          else if (v[1 - fav]) win = 1 - fav;
        end
        rv = pend && (age == 2);
        check("rnd req0_ready", req0_ready, win == 0);
        check("rnd req1_ready", req1_ready, win == 1);
        check("rnd rsp0_valid", rsp0_valid, rv && own == 0);
        check("rnd rsp1_valid", rsp1_valid, rv && own == 1);
        check("rnd busy", busy, pend);
        check("rnd done0_cnt", done0_cnt, cnt[0]);
        check("rnd done1_cnt", done1_cnt, cnt[1]);
        if (rv) begin
          check("rnd rsp_r", (own == 0) ? rsp0_r : rsp1_r, exp_res[W-1:0]);
          check("rnd rsp_ov", (own == 0) ? rsp0_ov : rsp1_ov, exp_res[W]);
        end
        if (win >= 0) begin
          pend = 1'b1; age = 1; own = win;
          exp_res = (win == 0) ? alu_ref(a0, b0, o0) : alu_ref(a1, b1, o1);
        end else if (pend) begin
          if (age == 1) age = 2;
          else if (rdy[own]) begin
            pend = 1'b0;
            cnt[own]++;
            fav = 1 - own;
          end
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
